// File: rtl/interleaver_pkg.sv
// Shared definitions for the interleaver SPI datapath: FSM states, SPI mode helpers, defaults.
package interleaver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CS_SETUP = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_CS_HOLD  = 3'd3,
        ST_GAP      = 3'd4
    } tx_state_e;

    localparam int unsigned SPI_MODE_0 = 0;
    localparam int unsigned SPI_MODE_1 = 1;
    localparam int unsigned SPI_MODE_2 = 2;
    localparam int unsigned SPI_MODE_3 = 3;

    localparam int unsigned DEFAULT_DATABYTES = 8;

    // Clock polarity is bit 1 of the mode number.
    function automatic logic spi_cpol(input int unsigned mode);
        return 1'(mode >> 1);
    endfunction

    // Clock phase is bit 0 of the mode number.
    function automatic logic spi_cpha(input int unsigned mode);
        return 1'(mode);
    endfunction

endpackage

// File: rtl/interleaved_frame_tx_half_tick.sv
// SPCK half-period timer: counts CLK_DIV cycles per half and pairs halves into bits.
module spi_half_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic phase_clr_i,
    output logic half_done_o,
    output logic bit_done_o
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic          half_done_c;

    // Half ends on the last count; a bit ends on the second half.
    always_comb begin
        half_done_c = en_i && (cnt_q == CW'(CLK_DIV - 1));
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        if (!en_i) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else begin
            cnt_d = half_done_c ? '0 : cnt_q + 1'b1;
            if (phase_clr_i) begin
                phase_d = 1'b0;
            end else if (half_done_c) begin
                phase_d = ~phase_q;
            end
        end
    end

    assign half_done_o = half_done_c;
    assign bit_done_o  = half_done_c & phase_q;

    // Counter and phase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/interleaved_frame_tx.sv
// One-deep frame buffer plus SPI master that re-serialises each interleaved frame MSB-first.
module interleaved_frame_tx
    import interleaver_pkg::*;
#(
    parameter int unsigned SPI_MODE  = 1,
    parameter int unsigned DATABYTES = DEFAULT_DATABYTES,
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [8*DATABYTES-1:0] i_Frame,
    input  logic                   i_Frame_Valid,
    input  logic                   i_Clr_Overflow,
    output logic                   o_SPCK,
    output logic                   o_MOSI,
    output logic                   o_CS_n,
    output logic                   o_Busy,
    output logic                   o_Overflow,
    output logic [CNT_W-1:0]       o_TX_Count
);

    localparam int unsigned W    = 8 * DATABYTES;
    localparam int unsigned BW   = $clog2(W);
    localparam logic        CPOL = spi_cpol(SPI_MODE);
    localparam logic        CPHA = spi_cpha(SPI_MODE);

    tx_state_e          state_q, state_d;
    logic [W-1:0]       buf_q, buf_d;
    logic               buf_full_q, buf_full_d;
    logic [W-1:0]       shreg_q, shreg_d;
    logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
    logic               prev_valid_q;
    logic               spck_q, spck_d;
    logic               mosi_q, mosi_d;
    logic               cs_n_q, cs_n_d;
    logic               busy_q, busy_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic new_frame, drain, ovf_event, phase_clr, half_done, bit_done;

    spi_half_tick #(.CLK_DIV(CLK_DIV)) u_half_tick (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (state_q != ST_IDLE),
        .phase_clr_i (phase_clr),
        .half_done_o (half_done),
        .bit_done_o  (bit_done)
    );

    // Next state, buffer handling, and next values of the registered outputs.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        count_d   = count_q;
        mosi_d    = mosi_q;
        spck_d    = CPOL;
        drain     = 1'b0;
        phase_clr = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (buf_full_q) begin
                    drain   = 1'b1;
                    shreg_d = buf_q;
                    state_d = ST_CS_SETUP;
                end
            end
            ST_CS_SETUP: begin
                if (half_done) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                    phase_clr = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (bit_done) begin
                    if (bit_cnt_q == BW'(W - 1)) begin
                        state_d = ST_CS_HOLD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shreg_d   = {shreg_q[W-2:0], 1'b0};
                    end
                end
            end
            ST_CS_HOLD: begin
                if (half_done) begin
                    state_d = ST_GAP;
                    count_d = count_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (half_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs track the state being entered so they line up with state_q.
        cs_n_d = !((state_d == ST_CS_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_CS_HOLD));
        if ((state_d == ST_CS_SETUP) || (state_d == ST_SHIFT)) begin
            mosi_d = shreg_d[W-1];
        end
        if (state_d == ST_SHIFT) begin
            if (state_q != ST_SHIFT) begin
                spck_d = CPHA ? ~CPOL : CPOL;
            end else if (half_done) begin
                spck_d = ~spck_q;
            end else begin
                spck_d = spck_q;
            end
        end

        // Single-entry buffer; a frame arriving while the slot drains takes the slot.
        new_frame  = i_Frame_Valid & ~prev_valid_q;
        ovf_event  = new_frame & buf_full_q & ~drain;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        if (drain) begin
            buf_full_d = 1'b0;
        end
        if (new_frame && !ovf_event) begin
            buf_d      = i_Frame;
            buf_full_d = 1'b1;
        end
        if (ovf_event) begin
            ovf_d = 1'b1;
        end else if (i_Clr_Overflow) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        busy_d = (state_d != ST_IDLE) || buf_full_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            buf_q        <= '0;
            buf_full_q   <= 1'b0;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            prev_valid_q <= 1'b0;
            spck_q       <= CPOL;
            mosi_q       <= 1'b0;
            cs_n_q       <= 1'b1;
            busy_q       <= 1'b0;
            ovf_q        <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            buf_full_q   <= buf_full_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            prev_valid_q <= i_Frame_Valid;
            spck_q       <= spck_d;
            mosi_q       <= mosi_d;
            cs_n_q       <= cs_n_d;
            busy_q       <= busy_d;
            ovf_q        <= ovf_d;
            count_q      <= count_d;
        end
    end

    assign o_SPCK     = spck_q;
    assign o_MOSI     = mosi_q;
    assign o_CS_n     = cs_n_q;
    assign o_Busy     = busy_q;
    assign o_Overflow = ovf_q;
    assign o_TX_Count = count_q;

endmodule

// File: tb/tb_interleaved_frame_tx.sv
// Bench: four transmitters (SPI modes 0..3, CLK_DIV=2) share stimulus; an SPI slave model decodes each.
module tb_interleaved_frame_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] frame;
    logic        valid;
    logic        clr;

    logic [3:0]  spck, mosi, cs_n, busy, ovf;
    logic [15:0] cnt [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        interleaved_frame_tx #(
            .SPI_MODE (g),
            .DATABYTES(8),
            .CLK_DIV  (2),
            .CNT_W    (16)
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .i_Frame       (frame),
            .i_Frame_Valid (valid),
            .i_Clr_Overflow(clr),
            .o_SPCK        (spck[g]),
            .o_MOSI        (mosi[g]),
            .o_CS_n        (cs_n[g]),
            .o_Busy        (busy[g]),
            .o_Overflow    (ovf[g]),
            .o_TX_Count    (cnt[g])
        );
    end

    // SPI slave model: samples MOSI on the edge the mode defines, measures CS_n low/high times.
    logic [63:0] rx_sr [4];
    logic [63:0] rx_hist [4][8];
    int          rx_bits [4];
    int          rx_frames [4];
    int          nbits_last [4];
    int          cs_low_cur [4];
    int          cs_low_last [4];
    int          cs_high_cur [4];
    int          cs_high_last [4];
    logic [3:0]  spck_prev, cs_prev;

    always @(negedge clk) begin
        for (int m = 0; m < 4; m++) begin
            if (!rst_n) begin
                rx_bits[m]     <= 0;
                cs_low_cur[m]  <= 0;
                cs_high_cur[m] <= 0;
                cs_prev[m]     <= 1'b1;
                spck_prev[m]   <= spck[m];
            end else begin
                if (!cs_n[m]) begin
                    // CPOL==CPHA (modes 0,3) samples on rising SPCK, otherwise falling.
                    if (spck[m] != spck_prev[m] && spck[m] == ((m == 0 || m == 3) ? 1'b1 : 1'b0)) begin
                        rx_sr[m]   <= {rx_sr[m][62:0], mosi[m]};
                        rx_bits[m] <= rx_bits[m] + 1;
                    end
                    if (cs_prev[m]) begin
                        cs_high_last[m] <= cs_high_cur[m];
                        cs_low_cur[m]   <= 1;
                    end else begin
                        cs_low_cur[m] <= cs_low_cur[m] + 1;
                    end
                end else begin
                    if (!cs_prev[m]) begin
                        rx_hist[m][rx_frames[m] % 8] <= rx_sr[m];
                        rx_frames[m]   <= rx_frames[m] + 1;
                        nbits_last[m]  <= rx_bits[m];
                        cs_low_last[m] <= cs_low_cur[m];
                        rx_bits[m]     <= 0;
                        cs_high_cur[m] <= 1;
                    end else begin
                        cs_high_cur[m] <= cs_high_cur[m] + 1;
                    end
                end
                spck_prev[m] <= spck[m];
                cs_prev[m]   <= cs_n[m];
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string name, input int m, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s mode%0d: got %h expected %h", name, m, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic wait_cnt(input logic [15:0] target);
        for (int k = 0; k < 3000 && cnt[1] != target; k++) tick();
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 3000 && busy != 4'b0000; k++) tick();
        chk("idle_reached", 0, 64'(busy), 64'h0);
        tick();
    endtask

    typedef struct {
        logic [63:0] frame;
        int          hold;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [4];
    int   base [4];
    logic [63:0] fa, fb, fc;

    initial begin
        // Single-frame vectors; the first one holds valid high far past one frame time.
        vecs[0] = '{frame: 64'hA5A5_0000_FFFF_1234, hold: 1000, exp_cnt: 16'd1};
        vecs[1] = '{frame: 64'h8000_0000_0000_0001, hold: 3,    exp_cnt: 16'd2};
        vecs[2] = '{frame: 64'hFFFF_FFFF_FFFF_FFFF, hold: 1,    exp_cnt: 16'd3};
        vecs[3] = '{frame: 64'h0000_0000_0000_0000, hold: 2,    exp_cnt: 16'd4};
        for (int m = 0; m < 4; m++) begin
            rx_frames[m] = 0;
            rx_sr[m]     = '0;
        end

        rst_n = 1'b0;
        valid = 1'b0;
        clr   = 1'b0;
        frame = '0;
        repeat (3) tick();

        for (int m = 0; m < 4; m++) begin
            chk("rst_spck", m, 64'(spck[m]), 64'(m >= 2));
            chk("rst_mosi", m, 64'(mosi[m]), 64'h0);
            chk("rst_cs_n", m, 64'(cs_n[m]), 64'h1);
            chk("rst_busy", m, 64'(busy[m]), 64'h0);
            chk("rst_ovf",  m, 64'(ovf[m]),  64'h0);
            chk("rst_cnt",  m, 64'(cnt[m]),  64'h0);
        end
        rst_n = 1'b1;
        repeat (2) tick();

        // Table-driven single frames across all four modes.
        for (int v = 0; v < 4; v++) begin
            for (int m = 0; m < 4; m++) base[m] = rx_frames[m];
            frame = vecs[v].frame;
            valid = 1'b1;
            repeat (vecs[v].hold) tick();
            valid = 1'b0;
            wait_cnt(vecs[v].exp_cnt);
            wait_idle();
            repeat (4) tick();
            for (int m = 0; m < 4; m++) begin
                chk("vec_data",   m, rx_hist[m][base[m] % 8], vecs[v].frame);
                chk("vec_frames", m, 64'(rx_frames[m] - base[m]), 64'd1);
                chk("vec_bits",   m, 64'(nbits_last[m]), 64'd64);
                chk("vec_cs_low", m, 64'(cs_low_last[m]), 64'd260);
                chk("vec_cnt",    m, 64'(cnt[m]), 64'(vecs[v].exp_cnt));
                chk("vec_ovf",    m, 64'(ovf[m]), 64'h0);
                chk("vec_idle_spck", m, 64'(spck[m]), 64'(m >= 2));
            end
        end

        // Three edges while busy: A and B go out back-to-back, C is dropped.
        fa = 64'h1111_2222_3333_4444;
        fb = 64'hDEAD_BEEF_0BAD_F00D;
        fc = 64'h5555_AAAA_5555_AAAA;
        for (int m = 0; m < 4; m++) base[m] = rx_frames[m];
        frame = fa; valid = 1'b1; cyc = 0;
        run_to(9);  valid = 1'b0;
        run_to(10); frame = fb; valid = 1'b1;
        run_to(19); valid = 1'b0;
        run_to(20); frame = fc; valid = 1'b1;
        run_to(21); valid = 1'b0;
        for (int m = 0; m < 4; m++) chk("ovf_set", m, 64'(ovf[m]), 64'h1);
        wait_cnt(16'd6);
        wait_idle();
        repeat (4) tick();
        for (int m = 0; m < 4; m++) begin
            chk("ovf_frames", m, 64'(rx_frames[m] - base[m]), 64'd2);
            chk("ovf_data_a", m, rx_hist[m][base[m] % 8], fa);
            chk("ovf_data_b", m, rx_hist[m][(base[m] + 1) % 8], fb);
            chk("ovf_gap",    m, 64'(cs_high_last[m]), 64'd3);
            chk("ovf_sticky", m, 64'(ovf[m]), 64'h1);
            chk("ovf_cnt",    m, 64'(cnt[m]), 64'd6);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        for (int m = 0; m < 4; m++) chk("ovf_clr", m, 64'(ovf[m]), 64'h0);

        // Third edge lands in the exact cycle the buffered frame drains: nothing is lost.
        for (int m = 0; m < 4; m++) base[m] = rx_frames[m];
        frame = fb; valid = 1'b1; cyc = 0;
        run_to(9);   valid = 1'b0;
        run_to(10);  frame = fc; valid = 1'b1;
        run_to(263); valid = 1'b0;
        run_to(264); frame = fa; valid = 1'b1;
        run_to(265); valid = 1'b0;
        for (int m = 0; m < 4; m++) chk("drain_no_ovf", m, 64'(ovf[m]), 64'h0);
        wait_cnt(16'd9);
        wait_idle();
        repeat (4) tick();
        for (int m = 0; m < 4; m++) begin
            chk("drain_frames", m, 64'(rx_frames[m] - base[m]), 64'd3);
            chk("drain_data0",  m, rx_hist[m][base[m] % 8], fb);
            chk("drain_data1",  m, rx_hist[m][(base[m] + 1) % 8], fc);
            chk("drain_data2",  m, rx_hist[m][(base[m] + 2) % 8], fa);
            chk("drain_ovf",    m, 64'(ovf[m]), 64'h0);
            chk("drain_cnt",    m, 64'(cnt[m]), 64'd9);
        end

        // Asynchronous reset at bit 30 of a frame, then a clean frame afterwards.
        frame = 64'hCAFE_F00D_1234_5678;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        for (int k = 0; k < 500 && rx_bits[1] != 30; k++) tick();
        chk("reach_bit30", 1, 64'(rx_bits[1]), 64'd30);
        #3;
        rst_n = 1'b0;
        #1;
        for (int m = 0; m < 4; m++) begin
            chk("arst_cs_n", m, 64'(cs_n[m]), 64'h1);
            chk("arst_spck", m, 64'(spck[m]), 64'(m >= 2));
            chk("arst_cnt",  m, 64'(cnt[m]),  64'h0);
            chk("arst_busy", m, 64'(busy[m]), 64'h0);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        for (int m = 0; m < 4; m++) base[m] = rx_frames[m];
        frame = 64'h0123_4567_89AB_CDEF;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        wait_cnt(16'd1);
        wait_idle();
        repeat (4) tick();
        for (int m = 0; m < 4; m++) begin
            chk("post_rst_frames", m, 64'(rx_frames[m] - base[m]), 64'd1);
            chk("post_rst_data",   m, rx_hist[m][base[m] % 8], 64'h0123_4567_89AB_CDEF);
            chk("post_rst_bits",   m, 64'(nbits_last[m]), 64'd64);
            chk("post_rst_cs_low", m, 64'(cs_low_last[m]), 64'd260);
            chk("post_rst_cnt",    m, 64'(cnt[m]), 64'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop in case a wait loop misbehaves.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
